// File: rtl/fetch_cache_pkg.sv
// Shared types, geometry and helpers for the direct-mapped instruction fetch cache.
// The address split is fixed here so the top and the tag store always agree on it.
package fetch_cache_pkg;

  localparam int ADDR_W = 23;
  localparam int IDX_W  = 4;
  localparam int LINES  = 1 << IDX_W;
  localparam int TAG_W  = ADDR_W - IDX_W - 2;

  // Fetches at or above this address target peripheral space and are never cached.
  localparam logic [ADDR_W-1:0] CACHE_LIMIT = 23'h40_0000;

  localparam logic [2:0] FUNCT3_MEM_B  = 3'b000;
  localparam logic [2:0] FUNCT3_MEM_H  = 3'b001;
  localparam logic [2:0] FUNCT3_MEM_W  = 3'b010;
  localparam logic [2:0] FUNCT3_MEM_BU = 3'b100;
  localparam logic [2:0] FUNCT3_MEM_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MISS_REQ  = 3'd1,
    MISS_WAIT = 3'd2,
    PASS_REQ  = 3'd3,
    PASS_WAIT = 3'd4
  } state_t;

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] addr);
    return addr[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] addr);
    return addr[ADDR_W-1:IDX_W+2];
  endfunction

endpackage

// File: rtl/fetch_cache_tags.sv
// Valid/tag/data storage for the fetch cache: combinational lookup, one fill port,
// a tag-qualified single-line invalidate and a flush that clears every valid bit.
module fetch_cache_tags
  import fetch_cache_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_hit,
  output logic [31:0]      lookup_data,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             inval_en,
  input  logic [IDX_W-1:0] inval_idx,
  input  logic [TAG_W-1:0] inval_tag,
  input  logic             flush_all
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign lookup_data = data_q[lookup_idx];

  // Flush wins over everything; a lookup in the flush cycle still sees the old contents.
  always_ff @(posedge clk) begin
    if (!reset || flush_all) begin
      valid_q <= '0;
    end else begin
      if (inval_en && (tag_q[inval_idx] == inval_tag)) begin
        valid_q[inval_idx] <= 1'b0;
      end
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/fetch_cache.sv
// Read-only, one-word-per-line instruction cache in front of the memory subsystem.
// Cacheable fetch hits complete in one cycle; everything else is forwarded unchanged.
module fetch_cache
  import fetch_cache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        cpu_fetch,
  input  logic [31:0] cpu_addr,
  input  logic [2:0]  cpu_funct3,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_datain,
  output logic [31:0] cpu_dataout,
  output logic        cpu_busy,
  output logic        cpu_valid,
  input  logic        flush,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_funct3,
  output logic        mem_memwrite,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_valid,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output state_t      dbg_state
);

  state_t      state_q, state_d;
  logic [31:0] req_addr_q;
  logic [2:0]  req_funct3_q;
  logic        req_memwrite_q;
  logic [31:0] req_datain_q;
  logic        fill_kill_q;

  logic        cacheable;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        hit_take, miss_take, pass_take, resp_take;
  logic        fill_en, inval_en;

  // Completion is tracked purely by mem_valid.
  logic unused_mem_busy;
  assign unused_mem_busy = mem_busy;

  assign cacheable = cpu_ce && cpu_fetch && !cpu_memwrite
                  && (cpu_funct3 == FUNCT3_MEM_W)
                  && (cpu_addr[1:0] == 2'b00)
                  && (cpu_addr[31:ADDR_W] == '0)
                  && (cpu_addr[ADDR_W-1:0] < CACHE_LIMIT);

  fetch_cache_tags u_tags (
    .clk         (clk),
    .reset       (reset),
    .lookup_idx  (idx_of(cpu_addr)),
    .lookup_tag  (tag_of(cpu_addr)),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .fill_en     (fill_en),
    .fill_idx    (idx_of(req_addr_q)),
    .fill_tag    (tag_of(req_addr_q)),
    .fill_data   (mem_dataout),
    .inval_en    (inval_en),
    .inval_idx   (idx_of(cpu_addr)),
    .inval_tag   (tag_of(cpu_addr)),
    .flush_all   (flush)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_ce) begin
          if (cacheable) begin
            state_d = lookup_hit ? IDLE : MISS_REQ;
          end else begin
            state_d = PASS_REQ;
          end
        end
      end
      MISS_REQ:  state_d = MISS_WAIT;
      MISS_WAIT: if (mem_valid) state_d = IDLE;
      PASS_REQ:  state_d = PASS_WAIT;
      PASS_WAIT: if (mem_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Requests arriving while busy are simply not looked at: only IDLE samples cpu_ce.
  always_comb begin
    mem_ce    = 1'b0;
    cpu_busy  = 1'b1;
    hit_take  = 1'b0;
    miss_take = 1'b0;
    pass_take = 1'b0;
    resp_take = 1'b0;
    fill_en   = 1'b0;
    inval_en  = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_busy  = 1'b0;
        hit_take  = cacheable && lookup_hit;
        miss_take = cacheable && !lookup_hit;
        pass_take = cpu_ce && !cacheable;
        inval_en  = cpu_ce && cpu_memwrite;
      end
      MISS_REQ, PASS_REQ: begin
        mem_ce = 1'b1;
      end
      MISS_WAIT: begin
        resp_take = mem_valid;
        fill_en   = mem_valid && !flush && !fill_kill_q;
      end
      PASS_WAIT: begin
        resp_take = mem_valid;
      end
      default: begin
        cpu_busy = 1'b1;
      end
    endcase
  end

  assign mem_addr     = req_addr_q;
  assign mem_funct3   = req_funct3_q;
  assign mem_memwrite = req_memwrite_q;
  assign mem_datain   = req_datain_q;
  assign dbg_state    = state_q;

  // A flush seen at any point while a miss is outstanding must keep that word out of the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_valid      <= 1'b0;
      cpu_dataout    <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      fill_kill_q    <= 1'b0;
      req_addr_q     <= '0;
      req_funct3_q   <= '0;
      req_memwrite_q <= 1'b0;
      req_datain_q   <= '0;
    end else begin
      cpu_valid <= hit_take || resp_take;
      if (hit_take) begin
        cpu_dataout <= lookup_data;
      end else if (resp_take) begin
        cpu_dataout <= mem_dataout;
      end

      if (hit_take && (hit_cnt != 16'hFFFF)) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      if (miss_take && (miss_cnt != 16'hFFFF)) begin
        miss_cnt <= miss_cnt + 16'd1;
      end

      if (miss_take || pass_take) begin
        req_addr_q     <= cpu_addr;
        req_funct3_q   <= cpu_funct3;
        req_memwrite_q <= cpu_memwrite;
        req_datain_q   <= cpu_datain;
        fill_kill_q    <= 1'b0;
      end else if (flush && (state_q != IDLE)) begin
        fill_kill_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_cache.sv
// Self-checking bench for fetch_cache: memory model with programmable latency,
// expected read data queued at issue time and compared on each cpu_valid pulse.
module tb_fetch_cache;
  import fetch_cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_ce, cpu_fetch, cpu_memwrite, flush;
  logic [31:0] cpu_addr, cpu_datain;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_dataout;
  logic        cpu_busy, cpu_valid;
  logic        mem_ce, mem_memwrite;
  logic [31:0] mem_addr, mem_datain;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_dataout = 32'h0;
  logic        mem_busy = 1'b0;
  logic        mem_valid = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int exp_h = 0;
  int exp_m = 0;
  logic [31:0] exp_q[$];

  fetch_cache dut (
    .clk(clk), .reset(reset),
    .cpu_ce(cpu_ce), .cpu_fetch(cpu_fetch), .cpu_addr(cpu_addr), .cpu_funct3(cpu_funct3),
    .cpu_memwrite(cpu_memwrite), .cpu_datain(cpu_datain), .cpu_dataout(cpu_dataout),
    .cpu_busy(cpu_busy), .cpu_valid(cpu_valid), .flush(flush),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_memwrite(mem_memwrite),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout), .mem_busy(mem_busy), .mem_valid(mem_valid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(reset && cpu_ce && cpu_busy)) else $error("protocol violation: cpu_ce while cpu_busy");
  end

  // ---------------- memory model ----------------
  logic [31:0] mem_words [int unsigned];
  int          mem_lat = 20;
  int          mem_cnt = 0;
  bit          mem_pending = 1'b0;
  logic [31:0] mem_rdata_pend = 32'h0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (mem_words.exists(int'(a[31:2]))) return mem_words[int'(a[31:2])];
    return 32'hC000_0000 ^ {a[31:2], 2'b00};
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    w = model_read(a);
    case (f3[1:0])
      2'b00:   w[8*a[1:0] +: 8] = d[7:0];
      2'b01:   w[16*a[1] +: 16] = d[15:0];
      default: w = d;
    endcase
    mem_words[int'(a[31:2])] = w;
  endfunction

  // mem_valid arrives mem_lat cycles after the mem_ce cycle (mem_lat >= 2).
  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (mem_pending) begin
      if (mem_cnt <= 1) begin
        mem_valid   <= 1'b1;
        mem_dataout <= mem_rdata_pend;
        mem_pending <= 1'b0;
        mem_busy    <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end else if (mem_ce) begin
      mem_pending <= 1'b1;
      mem_busy    <= 1'b1;
      mem_cnt     <= mem_lat - 1;
      if (mem_memwrite) begin
        model_write(mem_addr, mem_funct3, mem_datain);
        mem_rdata_pend <= 32'h0;
      end else begin
        mem_rdata_pend <= model_read(mem_addr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic f, input logic w,
                       input logic [2:0] f3, input logic [31:0] d, input logic fl);
    cpu_ce = 1'b1; cpu_fetch = f; cpu_memwrite = w; cpu_funct3 = f3;
    cpu_addr = a; cpu_datain = d; flush = fl;
    exp_q.push_back(w ? 32'h0 : model_read(a));
    @(posedge clk); #1;
    cpu_ce = 1'b0; cpu_fetch = 1'b0; cpu_memwrite = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output int nce, output logic [31:0] s_addr,
                           output logic [2:0] s_f3, output logic s_wr, output logic [31:0] s_wd);
    logic [31:0] exp;
    bit done;
    lat = 1; nce = 0; done = 0;
    s_addr = '0; s_f3 = '0; s_wr = 1'b0; s_wd = '0;
    while (!done && lat <= 100) begin
      @(negedge clk);
      if (mem_ce) begin
        nce++; s_addr = mem_addr; s_f3 = mem_funct3; s_wr = mem_memwrite; s_wd = mem_datain;
      end
      if (cpu_valid) begin
        done = 1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (cpu_dataout !== exp) begin
          n_fail++; $display("FAIL rdata: got %h expected %h", cpu_dataout, exp);
        end
        n_checks++;
        if (cpu_busy !== 1'b0) begin
          n_fail++; $display("FAIL busy_at_valid: got %b expected 0", cpu_busy);
        end
      end
      @(posedge clk); #1;
      if (!done) lat++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no cpu_valid within 100 cycles");
      exp_q.delete();
    end
  endtask

  task automatic access(input logic [31:0] a, input logic f, input logic w, input logic [2:0] f3,
                        input logic [31:0] d, input logic fl, output int lat, output int nce,
                        output logic [31:0] s_addr, output logic s_wr, output logic [31:0] s_wd);
    logic [2:0] s_f3;
    issue(a, f, w, f3, d, fl);
    wait_resp(lat, nce, s_addr, s_f3, s_wr, s_wd);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", cpu_valid); end
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", cpu_busy); end
    n_checks++; if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ce: got %b expected 0", mem_ce); end
    n_checks++; if (cpu_dataout !== 32'h0) begin n_fail++; $display("FAIL reset_dataout: got %h expected 0", cpu_dataout); end
    n_checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_miss_hit();
    int lat, nce; logic [31:0] sa, swd; logic swr;
    mem_lat = 20;
    access(32'h100, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_m++;
    n_checks++; if (lat != 22) begin n_fail++; $display("FAIL miss_latency: got %0d expected 22", lat); end
    n_checks++; if (nce != 1) begin n_fail++; $display("FAIL miss_mem_ce: got %0d expected 1", nce); end
    n_checks++; if (sa !== 32'h100) begin n_fail++; $display("FAIL miss_mem_addr: got %h expected 00000100", sa); end
    n_checks++; if (miss_cnt !== 16'(exp_m)) begin n_fail++; $display("FAIL miss_cnt: got %0d expected %0d", miss_cnt, exp_m); end
    access(32'h100, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_h++;
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL hit_latency: got %0d expected 1", lat); end
    n_checks++; if (nce != 0) begin n_fail++; $display("FAIL hit_mem_ce: got %0d expected 0", nce); end
    n_checks++; if (hit_cnt !== 16'(exp_h)) begin n_fail++; $display("FAIL hit_cnt: got %0d expected %0d", hit_cnt, exp_h); end
    mem_lat = 3;
  endtask

  task automatic test_conflict();
    int lat, nce; logic [31:0] sa, swd; logic swr;
    logic [31:0] seq [4] = '{32'h100, 32'h140, 32'h100, 32'h100};
    int exp_nce [4] = '{1, 1, 1, 0};
    pulse_flush();
    for (int i = 0; i < 4; i++) begin
      access(seq[i], 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd);
      if (exp_nce[i] == 1) exp_m++; else exp_h++;
      n_checks++; if (nce != exp_nce[i]) begin n_fail++; $display("FAIL conflict_mem_ce[%0d]: got %0d expected %0d", i, nce, exp_nce[i]); end
    end
    n_checks++; if (miss_cnt !== 16'(exp_m) || hit_cnt !== 16'(exp_h)) begin n_fail++; $display("FAIL conflict_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_h, exp_m); end
  endtask

  task automatic test_store_inval();
    int lat, nce; logic [31:0] sa, swd; logic swr;
    access(32'h100, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_h++;
    n_checks++; if (nce != 0) begin n_fail++; $display("FAIL store_pre_hit: got %0d mem_ce expected 0", nce); end
    access(32'h100, 0, 1, FUNCT3_MEM_W, 32'hDEADBEEF, 0, lat, nce, sa, swr, swd);
    n_checks++; if (nce != 1 || swr !== 1'b1 || swd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_fwd: got ce=%0d wr=%b data=%h expected 1/1/deadbeef", nce, swr, swd); end
    access(32'h100, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_m++;
    n_checks++; if (nce != 1) begin n_fail++; $display("FAIL store_inval_word: got %0d mem_ce expected 1", nce); end
    access(32'h100, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_h++;
    access(32'h101, 0, 1, FUNCT3_MEM_B, 32'h0000_0055, 0, lat, nce, sa, swr, swd);
    access(32'h100, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_m++;
    n_checks++; if (nce != 1) begin n_fail++; $display("FAIL store_inval_byte: got %0d mem_ce expected 1", nce); end
    n_checks++; if (model_read(32'h100) !== 32'hDEAD55EF) begin n_fail++; $display("FAIL byte_store_merge: got %h expected dead55ef", model_read(32'h100)); end
  endtask

  task automatic test_passthrough();
    int lat, nce; logic [31:0] sa, swd; logic swr;
    for (int i = 0; i < 2; i++) begin
      access(32'h0040_0000, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd);
      n_checks++; if (nce != 1 || sa !== 32'h0040_0000) begin n_fail++; $display("FAIL pass_periph[%0d]: got ce=%0d addr=%h expected 1/00400000", i, nce, sa); end
      access(32'h100, 0, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd);
      n_checks++; if (nce != 1 || swr !== 1'b0) begin n_fail++; $display("FAIL pass_load[%0d]: got ce=%0d wr=%b expected 1/0", i, nce, swr); end
    end
    access(32'h100, 1, 0, FUNCT3_MEM_HU, 0, 0, lat, nce, sa, swr, swd);
    n_checks++; if (nce != 1) begin n_fail++; $display("FAIL pass_half_fetch: got %0d mem_ce expected 1", nce); end
    n_checks++; if (hit_cnt !== 16'(exp_h) || miss_cnt !== 16'(exp_m)) begin n_fail++; $display("FAIL pass_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_h, exp_m); end
    access(32'h003F_FFFC, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_m++;
    access(32'h003F_FFFC, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_h++;
    n_checks++; if (nce != 0) begin n_fail++; $display("FAIL below_limit_hit: got %0d mem_ce expected 0", nce); end
  endtask

  task automatic test_flush();
    int lat, nce, bad; logic [31:0] sa, swd; logic swr; logic [2:0] sf3;
    for (int pass = 0; pass < 3; pass++) begin
      bad = 0;
      if (pass == 2) pulse_flush();
      for (int i = 0; i < 16; i++) begin
        access(32'h200 + 32'(4 * i), 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd);
        if (pass == 1) exp_h++; else exp_m++;
        if (nce != ((pass == 1) ? 0 : 1)) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL flush_fill_pass%0d: got %0d wrong hit/miss outcomes expected 0", pass, bad); end
    end
    n_checks++; if (hit_cnt !== 16'(exp_h) || miss_cnt !== 16'(exp_m)) begin n_fail++; $display("FAIL flush_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_h, exp_m); end
    access(32'h200, 1, 0, FUNCT3_MEM_W, 0, 1, lat, nce, sa, swr, swd); exp_h++;
    n_checks++; if (lat != 1 || nce != 0) begin n_fail++; $display("FAIL flush_same_cycle_hit: got lat=%0d ce=%0d expected 1/0", lat, nce); end
    access(32'h200, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_m++;
    n_checks++; if (nce != 1) begin n_fail++; $display("FAIL flush_after_hit: got %0d mem_ce expected 1", nce); end
    mem_lat = 6;
    issue(32'h300, 1, 0, FUNCT3_MEM_W, 0, 0); exp_m++;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_resp(lat, nce, sa, sf3, swr, swd);
    access(32'h300, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_m++;
    n_checks++; if (nce != 1) begin n_fail++; $display("FAIL flush_in_wait_nofill: got %0d mem_ce expected 1", nce); end
    mem_lat = 3;
  endtask

  task automatic test_reset_inflight();
    int lat, nce, stale, seen_mv; logic [31:0] sa, swd; logic swr;
    mem_lat = 20;
    issue(32'h380, 1, 0, FUNCT3_MEM_W, 0, 0);
    repeat (14) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    exp_h = 0; exp_m = 0;
    n_checks++; if (cpu_busy !== 1'b0 || cpu_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_reset_outs: got busy=%b valid=%b expected 0/0", cpu_busy, cpu_valid); end
    n_checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin n_fail++; $display("FAIL inflight_reset_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    stale = 0; seen_mv = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_valid) stale++;
      if (mem_valid) seen_mv++;
      @(posedge clk); #1;
    end
    n_checks++; if (stale != 0 || seen_mv != 1) begin n_fail++; $display("FAIL stale_mem_valid: got cpu_valid=%0d mem_valid=%0d expected 0/1", stale, seen_mv); end
    mem_lat = 3;
    access(32'h100, 1, 0, FUNCT3_MEM_W, 0, 0, lat, nce, sa, swr, swd); exp_m++;
    n_checks++; if (nce != 1 || miss_cnt !== 16'(exp_m)) begin n_fail++; $display("FAIL post_reset_miss: got ce=%0d miss=%0d expected 1/%0d", nce, miss_cnt, exp_m); end
  endtask

  initial begin
    cpu_ce = 1'b0; cpu_fetch = 1'b0; cpu_memwrite = 1'b0; flush = 1'b0;
    cpu_addr = '0; cpu_datain = '0; cpu_funct3 = FUNCT3_MEM_W;
    mem_words[int'(32'h100 >> 2)] = 32'h0050_0093;
    test_reset();
    test_miss_hit();
    test_conflict();
    test_store_inval();
    test_passthrough();
    test_flush();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_cache.md
Name: fetch_cache

Overview:
- Direct-mapped, one-word-per-line, read-only instruction cache between the core's memory port and the memory/peripheral subsystem (SPI SRAM, UART, I2C, GPIO, radio).
- Instruction fetches that hit return in one cycle, with no SPI SRAM transaction.
- Data loads, stores and uncacheable fetches pass through unchanged.
- Stores invalidate any matching line, so self-modifying code and bootloaded code stay coherent.

Parameters:
- ADDR_W, 23, width of the cacheable address (matches the program counter width).
- IDX_W, 4, index bits; the cache holds 2**IDX_W lines.
- CACHE_LIMIT, 23'h40_0000, fetch addresses at or above this are uncacheable (peripheral space).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cpu_ce  in  1  single-cycle request strobe from the core
- cpu_fetch  in  1  qualifies cpu_ce as an instruction fetch
- cpu_addr  in  32  byte address
- cpu_funct3  in  3  access size/sign, forwarded unchanged
- cpu_memwrite  in  1  store request
- cpu_datain  in  32  store data, forwarded unchanged
- cpu_dataout  out  32  read data
- cpu_busy  out  1  access in progress
- cpu_valid  out  1  one-cycle completion pulse
- flush  in  1  invalidate all lines (FENCE.I)
- mem_ce  out  1  request strobe to the memory subsystem
- mem_addr  out  32  forwarded address
- mem_funct3  out  3  forwarded access size/sign
- mem_memwrite  out  1  forwarded store request
- mem_datain  out  32  forwarded store data
- mem_dataout  in  32  memory read data
- mem_busy  in  1  memory access in progress
- mem_valid  in  1  memory completion pulse
- hit_cnt  out  16  saturating hit counter for debug/perf
- miss_cnt  out  16  saturating miss counter for debug/perf

Behaviour:
- Reset (reset==0 at a clk edge):
  - all line valid bits cleared; FSM goes to IDLE;
  - mem_ce, cpu_valid, cpu_busy = 0; cpu_dataout = 0; hit_cnt, miss_cnt = 0;
  - any memory transaction in flight is abandoned and its late mem_valid is ignored.
- Address split:
  - index = cpu_addr[IDX_W+1:2];
  - tag = cpu_addr[ADDR_W-1:IDX_W+2];
  - each line stores valid, tag and a 32-bit word in flops.
- Cacheable fetch: cpu_ce & cpu_fetch & !cpu_memwrite & cpu_funct3==W & cpu_addr[1:0]==0 & cpu_addr < CACHE_LIMIT & cpu_addr[31:ADDR_W]==0.
- FSM states:
  - IDLE: waits for cpu_ce.
    - Cacheable hit: cpu_valid=1 and cpu_dataout=line word in the next cycle; cpu_busy stays 0; hit_cnt++; remain in IDLE.
    - Cacheable miss: latch the request; go to MISS_REQ; miss_cnt++.
    - Otherwise (load, store, uncacheable fetch): latch the request; go to PASS_REQ.
    - A store invalidates the line at its index if the tags match, in the same cycle as cpu_ce, for any funct3 size.
  - MISS_REQ / PASS_REQ: drive mem_ce=1 for exactly one cycle, with the latched addr/funct3/memwrite/datain on the mem_* outputs. Then go to MISS_WAIT / PASS_WAIT.
  - MISS_WAIT: on mem_valid, write the line (valid=1, tag, mem_dataout), pulse cpu_valid with cpu_dataout=mem_dataout, return to IDLE.
  - PASS_WAIT: on mem_valid, pulse cpu_valid with cpu_dataout=mem_dataout, return to IDLE; no fill.
- cpu_busy = 1 in every state except IDLE; it deasserts in the same cycle cpu_valid pulses.
- Miss latency: memory latency + 2 cycles.
- mem_* outputs hold the latched values through the WAIT states; mem_ce is 0 outside the REQ states.
- cpu_ce while cpu_busy=1 is a protocol violation; it is ignored and an assertion in the bench flags it.
- flush:
  - clears all valid bits at the next edge;
  - a hit lookup in the same cycle as flush still returns the old data;
  - flush during MISS_WAIT: the fill is suppressed, but cpu_valid still returns the fetched data.
- Store during an IDLE hit cannot occur: the core issues one request at a time.
- Counters saturate at 16'hFFFF.

Decomposition:
- Package fetch_cache_pkg:
  - FSM state enum (IDLE, MISS_REQ, MISS_WAIT, PASS_REQ, PASS_WAIT);
  - FUNCT3_MEM_W constant, shared with the existing constants;
  - helper functions idx_of() and tag_of().
- One sub-module, fetch_cache_tags: valid/tag/data storage with lookup, fill, single-line invalidate and flush-all ports. The FSM and counters stay in fetch_cache.

Test Plan:
- Reset, then fetch 0x000100 with memory model latency 20 → mem_ce one cycle after cpu_ce; cpu_valid at cycle 22 with data 0x00500093; miss_cnt=1. Refetch → cpu_valid next cycle, no mem_ce, hit_cnt=1.
- Fetch 0x000100 then 0x000140 (same index, different tag), then 0x000100 again → three misses; the line ends holding 0x000100's word.
- Fetch 0x000100 (fill), store word 0xDEADBEEF to 0x000100 via passthrough, fetch again → miss, returns 0xDEADBEEF. A byte store to 0x000101 also invalidates the line.
- Fetch to 0x400000 and a load from 0x000100 → passthrough every time; no fill; hit_cnt unchanged on repeat.
- Fill 16 lines, pulse flush, refetch all 16 → 16 misses. Flush during MISS_WAIT → data returned, next fetch of the same address misses.
- Drop reset low during MISS_WAIT → next cycle busy=0, valid=0, counters=0; a stale mem_valid 5 cycles later produces no cpu_valid.
